uart_buffered: RTL and testbench

UART_BUFFERED -- requirements
Module: uart_buffered

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_buffered_if.sv | 23 ++
 rtl/uart_sync_fifo.sv | 64 ++++++
 rtl/uart_buffered.sv | 268 ++++++++++++++++++++++++++
 tb/tb_uart_buffered.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared constants, FSM encodings and the parity helper for the buffered UART.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  // Data is zero-extended to 9 bits by callers; zero padding leaves the XOR unchanged.
  function automatic logic parity_of(input logic [8:0] data, input int mode);
    parity_of = (mode == PARITY_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_buffered_if.sv
// FIFO access bundle: a push side and a first-word-fall-through pop side.
// Handshake: a transfer happens on a rising edge where valid && ready; valid never
// waits on ready, push_ready means "not full", pop_valid means "not empty".
interface uart_buffered_if #(
  parameter int WIDTH = 8
);
  logic             push_valid;
  logic             push_ready;
  logic [WIDTH-1:0] push_data;
  logic             pop_valid;
  logic             pop_ready;
  logic [WIDTH-1:0] pop_data;

  modport master (
    output push_valid, push_data, pop_ready,
    input  push_ready, pop_valid, pop_data
  );

  modport slave (
    input  push_valid, push_data, pop_ready,
    output push_ready, pop_valid, pop_data
  );
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO, power-of-two depth, first-word fall-through read port.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input logic             clk,
  input logic             reset,
  uart_buffered_if.slave  f
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push_fire;
  logic             pop_fire;

  assign f.push_ready = (count_q != FULL_COUNT);
  assign f.pop_valid  = (count_q != '0);
  // Empty reads return zero so the head outputs are clean after reset.
  assign f.pop_data   = f.pop_valid ? mem_q[rd_ptr_q] : '0;

  assign pop_fire  = f.pop_valid && f.pop_ready;
  // A push into a full FIFO is still taken when the same edge frees a slot.
  assign push_fire = f.push_valid && (f.push_ready || pop_fire);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_fire) begin
      mem_d[wr_ptr_q] = f.push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_fire) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_fire, pop_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/uart_buffered.sv
// Full-duplex UART with a TX FIFO feeding the transmitter and an RX FIFO that
// stores each received word together with its frame/parity error flags.
module uart_buffered
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_ready,
  output logic                  tx_busy,
  output logic                  serial_out,
  input  logic                  serial_in,
  output logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_ready,
  output logic                  rx_parity_error,
  output logic                  rx_frame_error,
  output logic                  rx_overrun
);

  localparam int RX_W  = DATA_WIDTH + 2;
  localparam int CNT_W = $clog2(STOP_BITS * CLKS_PER_BIT + 1);
  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);
  localparam bit HAS_PARITY = (PARITY_MODE != PARITY_NONE);

  uart_buffered_if #(.WIDTH(DATA_WIDTH)) tx_fifo_if ();
  uart_buffered_if #(.WIDTH(RX_W))       rx_fifo_if ();

  uart_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .f     (tx_fifo_if)
  );

  uart_sync_fifo #(.WIDTH(RX_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .f     (rx_fifo_if)
  );

  // ---------------- transmitter ----------------
  tx_state_e             tx_state_q, tx_state_d;
  logic [CNT_W-1:0]      tx_cnt_q, tx_cnt_d;
  logic [IDX_W-1:0]      tx_idx_q, tx_idx_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic                  serial_out_q, serial_out_d;
  logic                  tx_pop;
  logic                  tx_bit_end;
  logic                  tx_stop_end;
  logic                  tx_parity;

  // Gate with tx_ready so a pop on a full FIFO never sneaks a user word in.
  assign tx_fifo_if.push_valid = tx_valid && tx_fifo_if.push_ready;
  assign tx_fifo_if.push_data  = tx_data;
  assign tx_fifo_if.pop_ready  = tx_pop;

  assign tx_ready    = tx_fifo_if.push_ready;
  assign tx_busy     = tx_fifo_if.pop_valid || (tx_state_q != TX_IDLE);
  assign serial_out  = serial_out_q;
  assign tx_bit_end  = (tx_cnt_q == BIT_LAST);
  assign tx_stop_end = (tx_cnt_q == STOP_LAST);
  assign tx_parity   = parity_of(9'(tx_shift_q), PARITY_MODE);

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q   <= TX_IDLE;
      tx_cnt_q     <= '0;
      tx_idx_q     <= '0;
      tx_shift_q   <= '0;
      serial_out_q <= 1'b1;
    end else begin
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_idx_q     <= tx_idx_d;
      tx_shift_q   <= tx_shift_d;
      serial_out_q <= serial_out_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (tx_fifo_if.pop_valid) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_fifo_if.pop_data;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          tx_cnt_d = '0;
          if (tx_idx_q == IDX_LAST) begin
            if (HAS_PARITY) tx_state_d = TX_PARITY;
            else            tx_state_d = TX_STOP;
          end else begin
            tx_idx_d = tx_idx_q + 1'b1;
          end
        end
      end
      TX_PARITY: begin
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_stop_end) begin
          tx_cnt_d = '0;
          // Chain straight into the next start bit so queued words leave gap-free.
          if (tx_fifo_if.pop_valid) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_fifo_if.pop_data;
            tx_state_d = TX_START;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // The line is registered, so it trails the FSM state by one cycle.
  always_comb begin
    serial_out_d = 1'b1;
    case (tx_state_q)
      TX_START:  serial_out_d = 1'b0;
      TX_DATA:   serial_out_d = tx_shift_q[tx_idx_q];
      TX_PARITY: serial_out_d = tx_parity;
      default:   serial_out_d = 1'b1;
    endcase
  end

  // ---------------- receiver ----------------
  rx_state_e             rx_state_q, rx_state_d;
  logic [CNT_W-1:0]      rx_cnt_q, rx_cnt_d;
  logic [IDX_W-1:0]      rx_idx_q, rx_idx_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic                  rx_perr_q, rx_perr_d;
  logic                  overrun_q, overrun_d;
  logic                  sync1_q, sync2_q, prev_q;
  logic                  rx_push;
  logic                  rx_bit_end;
  logic                  rx_half_end;

  assign rx_bit_end  = (rx_cnt_q == BIT_LAST);
  assign rx_half_end = (rx_cnt_q == HALF_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= serial_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_perr_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_perr_q  <= rx_perr_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_perr_d  = rx_perr_q;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (prev_q && !sync2_q) rx_state_d = RX_START;
      end
      RX_START: begin
        // Half a bit in: a line back high means the edge was a glitch.
        if (rx_half_end) begin
          rx_cnt_d  = '0;
          rx_idx_d  = '0;
          rx_perr_d = 1'b0;
          if (sync2_q) rx_state_d = RX_IDLE;
          else         rx_state_d = RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_bit_end) begin
          rx_cnt_d             = '0;
          rx_shift_d[rx_idx_q] = sync2_q;
          if (rx_idx_q == IDX_LAST) begin
            if (HAS_PARITY) rx_state_d = RX_PARITY;
            else            rx_state_d = RX_STOP;
          end else begin
            rx_idx_d = rx_idx_q + 1'b1;
          end
        end
      end
      RX_PARITY: begin
        if (rx_bit_end) begin
          rx_cnt_d   = '0;
          rx_perr_d  = (sync2_q != parity_of(9'(rx_shift_q), PARITY_MODE));
          rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_bit_end) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_push   = (rx_state_q == RX_STOP) && rx_bit_end;
    overrun_d = rx_push && !rx_fifo_if.push_ready && !(rx_fifo_if.pop_valid && rx_ready);
  end

  assign rx_fifo_if.push_valid = rx_push;
  assign rx_fifo_if.push_data  = {~sync2_q, rx_perr_q, rx_shift_q};
  assign rx_fifo_if.pop_ready  = rx_ready;

  assign rx_valid        = rx_fifo_if.pop_valid;
  assign rx_data         = rx_fifo_if.pop_data[DATA_WIDTH-1:0];
  assign rx_parity_error = rx_fifo_if.pop_data[DATA_WIDTH];
  assign rx_frame_error  = rx_fifo_if.pop_data[DATA_WIDTH+1];
  assign rx_overrun      = overrun_q;

endmodule

// File: tb/tb_uart_buffered.sv
// Directed bench for uart_buffered at 4 clocks/bit, 8 data bits, even parity, 1 stop bit.
module tb_uart_buffered;

  localparam int CPB = 4;

  logic       clk;
  logic       reset;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_busy;
  logic       serial_out;
  logic       serial_in;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_parity_error;
  logic       rx_frame_error;
  logic       rx_overrun;

  logic       loopback;
  logic       drv_line;
  int         n_checks;
  int         n_fail;
  int         ovr_cnt;
  logic [9:0] exp_q[$];

  assign serial_in = loopback ? serial_out : drv_line;

  uart_buffered #(
    .DATA_WIDTH   (8),
    .PARITY_MODE  (1),
    .STOP_BITS    (1),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .tx_valid        (tx_valid),
    .tx_data         (tx_data),
    .tx_ready        (tx_ready),
    .tx_busy         (tx_busy),
    .serial_out      (serial_out),
    .serial_in       (serial_in),
    .rx_valid        (rx_valid),
    .rx_data         (rx_data),
    .rx_ready        (rx_ready),
    .rx_parity_error (rx_parity_error),
    .rx_frame_error  (rx_frame_error),
    .rx_overrun      (rx_overrun)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    ovr_cnt = 0;
    forever begin
      @(negedge clk);
      if (rx_overrun) ovr_cnt = ovr_cnt + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks: all called at #1 after a rising edge
  task automatic drive_bit(input logic b);
    drv_line = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(s);
    drive_bit(1'b1);
    drive_bit(1'b1);
  endtask

  task automatic push_tx(input logic [7:0] d);
    tx_valid = 1'b1;
    tx_data  = d;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  // scoreboard: pop n entries and compare each against the expected queue
  task automatic drain_check(input int n);
    logic [9:0] e;
    for (int i = 0; i < n; i++) begin
      check_eq("rx_valid_head", 32'(rx_valid), 32'd1);
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = 10'h3ff;
      check_eq("rx_data", 32'(rx_data), 32'(e[7:0]));
      check_eq("rx_parity_error", 32'(rx_parity_error), 32'(e[8]));
      check_eq("rx_frame_error", 32'(rx_frame_error), 32'(e[9]));
      rx_ready = 1'b1;
      @(posedge clk);
      #1;
      rx_ready = 1'b0;
    end
    check_eq("rx_valid_drained", 32'(rx_valid), 32'd0);
  endtask

  initial begin
    logic [10:0] a5_bits;
    int          ovr_base;
    logic [7:0]  d;

    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    rx_ready = 1'b0;
    loopback = 1'b0;
    drv_line = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // reset state
    check_eq("rst_serial_out", 32'(serial_out), 32'd1);
    check_eq("rst_tx_ready", 32'(tx_ready), 32'd1);
    check_eq("rst_tx_busy", 32'(tx_busy), 32'd0);
    check_eq("rst_rx_valid", 32'(rx_valid), 32'd0);
    check_eq("rst_rx_data", 32'(rx_data), 32'd0);
    check_eq("rst_perr", 32'(rx_parity_error), 32'd0);
    check_eq("rst_ferr", 32'(rx_frame_error), 32'd0);
    check_eq("rst_overrun", 32'(rx_overrun), 32'd0);

    // 0xA5 waveform: start, LSB-first data, even parity 0, stop (index 0 = start)
    a5_bits = 11'b1_0_10100101_0;
    repeat (2) @(posedge clk);
    #1;
    push_tx(8'hA5);
    check_eq("a5_busy", 32'(tx_busy), 32'd1);
    check_eq("a5_edge0_high", 32'(serial_out), 32'd1);
    @(posedge clk);
    #1;
    check_eq("a5_edge1_high", 32'(serial_out), 32'd1);
    for (int slot = 0; slot < 11; slot++) begin
      for (int c = 0; c < CPB; c++) begin
        @(posedge clk);
        #1;
        check_eq($sformatf("a5_slot%0d_cyc%0d", slot, c), 32'(serial_out), 32'(a5_bits[slot]));
      end
    end
    repeat (3) @(posedge clk);
    #1;
    check_eq("a5_idle_after", 32'(serial_out), 32'd1);
    check_eq("a5_not_busy", 32'(tx_busy), 32'd0);

    // loopback, three back-to-back frames
    loopback = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    @(posedge clk);
    #1;
    tx_data = 8'hFF;
    @(posedge clk);
    #1;
    tx_data = 8'h3C;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    repeat (43) @(posedge clk);
    #1;
    check_eq("b2b_stop1", 32'(serial_out), 32'd1);
    @(posedge clk);
    #1;
    check_eq("b2b_start2", 32'(serial_out), 32'd0);
    exp_q.push_back({2'b00, 8'h00});
    exp_q.push_back({2'b00, 8'hFF});
    exp_q.push_back({2'b00, 8'h3C});
    repeat (120) @(posedge clk);
    #1;
    check_eq("loop_tx_done", 32'(tx_busy), 32'd0);
    drain_check(3);
    loopback = 1'b0;

    // bad parity, bad stop, then a clean frame
    send_frame(8'h5A, 1'b1, 1'b1);
    exp_q.push_back({2'b01, 8'h5A});
    send_frame(8'h33, 1'b0, 1'b0);
    exp_q.push_back({2'b10, 8'h33});
    send_frame(8'h81, 1'b0, 1'b1);
    exp_q.push_back({2'b00, 8'h81});
    drain_check(3);

    // one-cycle glitch must not start a frame
    ovr_base = ovr_cnt;
    drv_line = 1'b0;
    @(posedge clk);
    #1;
    drv_line = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check_eq("glitch_no_push", 32'(rx_valid), 32'd0);

    // nine frames with no pops: eight kept, one dropped
    for (int i = 1; i <= 9; i++) begin
      d = 8'(i);
      send_frame(d, ^d, 1'b1);
      if (i <= 8) exp_q.push_back({2'b00, d});
      if (i == 8) check_eq("ovr_none_after8", 32'(ovr_cnt - ovr_base), 32'd0);
    end
    check_eq("ovr_once_after9", 32'(ovr_cnt - ovr_base), 32'd1);
    drain_check(8);

    // reset in the middle of a TX data bit
    send_frame(8'h11, 1'b0, 1'b1);
    check_eq("pre_rst_rx_valid", 32'(rx_valid), 32'd1);
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_eq("pre_rst_data_low", 32'(serial_out), 32'd0);
    check_eq("pre_rst_busy", 32'(tx_busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("mid_rst_serial_out", 32'(serial_out), 32'd1);
    check_eq("mid_rst_tx_busy", 32'(tx_busy), 32'd0);
    check_eq("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
    check_eq("mid_rst_tx_ready", 32'(tx_ready), 32'd1);
    check_eq("mid_rst_rx_data", 32'(rx_data), 32'd0);
    repeat (60) @(posedge clk);
    #1;
    check_eq("post_rst_line_idle", 32'(serial_out), 32'd1);
    check_eq("post_rst_not_busy", 32'(tx_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
